mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 85 ++++++++
 tb/tb_mem_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering read/write requests after a fixed wait latency.
module mem_responder #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        addr_err
);
    localparam int          AW    = $clog2(WORDS);
    localparam logic [31:0] LIMIT = 32'(4 * WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic          rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   mem [WORDS];
    logic [AW-1:0] idx;
    logic          err, resp;
    assign idx       = addr_q[AW+1:2];
    assign resp      = state_q == RESP;
    assign err       = (addr_q[1:0] != 2'b00) || (addr_q >= LIMIT) || (rd_q && wr_q);
    assign mem_ready = resp;
    assign mem_busy  = state_q != IDLE;
    assign addr_err  = resp && err;
    assign read_data = (resp && rd_q && !err) ? mem[idx] : rdata_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (mem_read || mem_write) begin
                state_d = (LATENCY == 0) ? RESP : WAIT;
                cnt_d   = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);
                addr_d  = addr;
                wdata_d = write_data;
                rd_d    = mem_read;
                wr_d    = mem_write;
            end
            WAIT: begin
                state_d = (cnt_q == 3'd0) ? RESP : WAIT;
                cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = read_data;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end
    // Memory is never cleared; a reset edge that lands on RESP aborts the commit.
    always_ff @(posedge clk) begin
        if (!rst && resp && wr_q && !err) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at LATENCY=2 and LATENCY=0.
module tb_mem_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        rd2 = 1'b0, wr2 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] ad2 = '0, wd2 = '0, ad0 = '0, wd0 = '0;
    logic [31:0] rdat2, rdat0;
    logic        rdy2, bsy2, err2, rdy0, bsy0, err0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.WORDS(256), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .mem_read(rd2), .mem_write(wr2), .addr(ad2), .write_data(wd2),
        .read_data(rdat2), .mem_ready(rdy2), .mem_busy(bsy2), .addr_err(err2));
    mem_responder #(.WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .addr(ad0), .write_data(wd0),
        .read_data(rdat0), .mem_ready(rdy0), .mem_busy(bsy0), .addr_err(err0));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn2(input string tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic chg, input logic [31:0] an,
                        input logic [31:0] dn, input logic eerr, input logic [31:0] erd);
        rd2 = r; wr2 = w; ad2 = a; wd2 = d;
        step();
        chk({tag, "_busy1"}, 32'(bsy2), 32'd1);
        chk({tag, "_rdy1"}, 32'(rdy2), 32'd0);
        if (chg) begin ad2 = an; wd2 = dn; end
        step();
        chk({tag, "_busy2"}, 32'(bsy2), 32'd1);
        chk({tag, "_rdy2"}, 32'(rdy2), 32'd0);
        step();
        chk({tag, "_rdy3"}, 32'(rdy2), 32'd1);
        chk({tag, "_busy3"}, 32'(bsy2), 32'd1);
        chk({tag, "_err"}, 32'(err2), 32'(eerr));
        chk({tag, "_rdata"}, rdat2, erd);
        rd2 = 1'b0; wr2 = 1'b0;
        step();
        chk({tag, "_rdy4"}, 32'(rdy2), 32'd0);
        chk({tag, "_busy4"}, 32'(bsy2), 32'd0);
        chk({tag, "_hold"}, rdat2, erd);
    endtask

    initial begin
        rd2 = 1'b1; ad2 = 32'h10;
        step();
        chk("rst_rdy", 32'(rdy2), 32'd0);
        chk("rst_busy", 32'(bsy2), 32'd0);
        chk("rst_err", 32'(err2), 32'd0);
        chk("rst_rdata", rdat2, 32'd0);
        step();
        chk("rst_req_ignored", 32'(bsy2), 32'd0);
        rst = 1'b0; rd2 = 1'b0;
        step();
        chk("idle_busy", 32'(bsy2), 32'd0);
        txn2("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0, 32'h0);
        txn2("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 0, 0, 1'b0, 32'hDEADBEEF);
        txn2("wr20", 1'b0, 1'b1, 32'h20, 32'h11112222, 1'b0, 0, 0, 1'b0, 32'hDEADBEEF);
        txn2("rd13", 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 0, 0, 1'b1, 32'hDEADBEEF);
        txn2("rd400", 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 0, 0, 1'b1, 32'hDEADBEEF);
        txn2("rw20", 1'b1, 1'b1, 32'h20, 32'h99999999, 1'b0, 0, 0, 1'b1, 32'hDEADBEEF);
        txn2("rd20a", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 0, 0, 1'b0, 32'h11112222);
        wr2 = 1'b1; ad2 = 32'h20; wd2 = 32'h55555555;
        step();
        chk("abort_busy", 32'(bsy2), 32'd1);
        rst = 1'b1; wr2 = 1'b0;
        step();
        chk("abort_rdy", 32'(rdy2), 32'd0);
        chk("abort_busy0", 32'(bsy2), 32'd0);
        chk("abort_err", 32'(err2), 32'd0);
        chk("abort_rdata", rdat2, 32'd0);
        rst = 1'b0;
        step();
        chk("abort_norsp", 32'(rdy2), 32'd0);
        txn2("rd20b", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 0, 0, 1'b0, 32'h11112222);
        txn2("wr40", 1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0, 0, 0, 1'b0, 32'h11112222);
        txn2("wr30chg", 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1, 32'h40, 32'h0BADBEEF, 1'b0, 32'h11112222);
        txn2("rd30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 0, 0, 1'b0, 32'hCAFEF00D);
        txn2("rd40", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 0, 0, 1'b0, 32'h12345678);
        wr0 = 1'b1; ad0 = 32'h0; wd0 = 32'hA0A0A0A0;
        step();
        chk("l0_wr0_rdy", 32'(rdy0), 32'd1);
        chk("l0_wr0_busy", 32'(bsy0), 32'd1);
        wr0 = 1'b0;
        step();
        chk("l0_wr0_idle", 32'(rdy0), 32'd0);
        wr0 = 1'b1; ad0 = 32'h4; wd0 = 32'hB4B4B4B4;
        step();
        chk("l0_wr4_rdy", 32'(rdy0), 32'd1);
        wr0 = 1'b0;
        step();
        rd0 = 1'b1; ad0 = 32'h0;
        step();
        chk("l0_rd0_rdy", 32'(rdy0), 32'd1);
        chk("l0_rd0_err", 32'(err0), 32'd0);
        chk("l0_rd0_data", rdat0, 32'hA0A0A0A0);
        ad0 = 32'h4;
        step();
        chk("l0_gap_rdy", 32'(rdy0), 32'd0);
        chk("l0_gap_busy", 32'(bsy0), 32'd0);
        chk("l0_gap_hold", rdat0, 32'hA0A0A0A0);
        step();
        chk("l0_rd4_rdy", 32'(rdy0), 32'd1);
        chk("l0_rd4_data", rdat0, 32'hB4B4B4B4);
        rd0 = 1'b0;
        step();
        chk("l0_rd4_drop", 32'(rdy0), 32'd0);
        chk("l0_rd4_hold", rdat0, 32'hB4B4B4B4);
        rd0 = 1'b1; ad0 = 32'h13;
        step();
        chk("l0_err_rdy", 32'(rdy0), 32'd1);
        chk("l0_err_flag", 32'(err0), 32'd1);
        chk("l0_err_data", rdat0, 32'hB4B4B4B4);
        rd0 = 1'b0;
        step();
        chk("l0_err_hold", rdat0, 32'hB4B4B4B4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
